// File: rtl/alu_seq_if.sv
// Handshake bundle between decode (master) and the sequential ALU (slave).
// Both sides use valid/ready: a transfer happens on a rising edge where valid and ready are both 1.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic [2:0]       alu_control;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zero;
  logic             alu_compare;

  modport master (
    output in_valid, srcA, srcB, alu_control, out_ready,
    input  in_ready, out_valid, alu_out, alu_zero, alu_compare
  );

  modport slave (
    input  in_valid, srcA, srcB, alu_control, out_ready,
    output in_ready, out_valid, alu_out, alu_zero, alu_compare
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU: add/sub/and/srl in one cycle, shift-add multiply over WIDTH cycles.
// Define ALU_SEQ_DIV_EN to add the restoring divider (divu/remu); otherwise those ops return 0.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  alu_seq_if.slave   bus,
  output logic [1:0] dbg_state
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] single_res;
  logic [WIDTH-1:0] iter_res;
  logic             is_iter;

`ifdef ALU_SEQ_DIV_EN
  logic [2:0]       op_q;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quot;
  logic [WIDTH:0]   trial;
  logic             ge;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quot_next;
`endif

  assign dbg_state    = state;
  assign bus.alu_zero = (bus.alu_out == '0);

  always_comb begin
    single_res = '0;
    case (bus.alu_control)
      3'b000:  single_res = bus.srcA + bus.srcB;
      3'b001:  single_res = bus.srcA - bus.srcB;
      3'b010:  single_res = bus.srcA & bus.srcB;
      3'b011:  single_res = bus.srcA >> bus.srcB[SHW-1:0];
      default: single_res = '0;
    endcase
  end

`ifdef ALU_SEQ_DIV_EN
  assign is_iter = (bus.alu_control == 3'b100) || (bus.alu_control == 3'b101) ||
                   (bus.alu_control == 3'b110);
`else
  assign is_iter = (bus.alu_control == 3'b100);
`endif

  // Multiply step: partial product A<<cnt when B[cnt] is set.
  assign acc_next = acc + (b_q[cnt] ? (a_q << cnt) : '0);

`ifdef ALU_SEQ_DIV_EN
  // Restoring divide, MSB first; ~cnt is WIDTH-1-cnt because WIDTH is a power of two.
  // A zero divisor naturally yields all-ones quotient and remainder == dividend.
  always_comb begin
    trial     = {rem, a_q[~cnt]};
    ge        = (trial >= {1'b0, b_q});
    rem_next  = ge ? (trial[WIDTH-1:0] - b_q) : trial[WIDTH-1:0];
    quot_next = {quot[WIDTH-2:0], ge};
  end

  always_comb begin
    iter_res = acc_next;
    case (op_q)
      3'b101:  iter_res = quot_next;
      3'b110:  iter_res = rem_next;
      default: iter_res = acc_next;
    endcase
  end
`else
  assign iter_res = acc_next;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      bus.in_ready    <= 1'b1;
      bus.out_valid   <= 1'b0;
      bus.alu_out     <= '0;
      bus.alu_compare <= 1'b0;
      cnt             <= '0;
      a_q             <= '0;
      b_q             <= '0;
      acc             <= '0;
`ifdef ALU_SEQ_DIV_EN
      op_q            <= '0;
      rem             <= '0;
      quot            <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            bus.alu_compare <= (bus.srcA == bus.srcB);
            bus.in_ready    <= 1'b0;
            if (is_iter) begin
              a_q   <= bus.srcA;
              b_q   <= bus.srcB;
              acc   <= '0;
              cnt   <= '0;
`ifdef ALU_SEQ_DIV_EN
              op_q  <= bus.alu_control;
              rem   <= '0;
              quot  <= '0;
`endif
              state <= BUSY;
            end else begin
              bus.alu_out   <= single_res;
              bus.out_valid <= 1'b1;
              state         <= DONE;
            end
          end
        end
        BUSY: begin
          cnt  <= cnt + 1'b1;
          acc  <= acc_next;
`ifdef ALU_SEQ_DIV_EN
          rem  <= rem_next;
          quot <= quot_next;
`endif
          // Last iteration: the counter wraps to 0 as we leave BUSY.
          if (&cnt) begin
            bus.alu_out   <= iter_res;
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          state         <= IDLE;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed and random ops scored against a reference model,
// plus backpressure, idle out_ready and reset-abort scenarios.
module tb_alu_seq;
  localparam int W = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;
  int         checks = 0;
  int         errors = 0;

  // {compare, result} captured when each op is driven
  logic [W:0] exp_q[$];

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W-1:0] r;
    logic [4:0]   sh;
    sh = b[4:0];
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a >> sh;
      3'd4: r = a * b;
`ifdef ALU_SEQ_DIV_EN
      3'd5: r = (b == 0) ? {W{1'b1}} : a / b;
      3'd6: r = (b == 0) ? a : a % b;
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int exp_latency(input logic [2:0] op);
`ifdef ALU_SEQ_DIV_EN
    if (op == 3'd4 || op == 3'd5 || op == 3'd6) return W + 1;
`else
    if (op == 3'd4) return W + 1;
`endif
    return 1;
  endfunction

  // Drive one op, wait for the result, score it, optionally stall in DONE, then drain.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold);
    int         n;
    logic       ready_seen;
    logic [W:0] e;
    @(negedge clk);
    check("in_ready_idle", bus.in_ready, 1);
    bus.in_valid    = 1'b1;
    bus.srcA        = a;
    bus.srcB        = b;
    bus.alu_control = op;
    exp_q.push_back({a == b, model(op, a, b)});
    @(posedge clk);
    #1;
    bus.in_valid    = 1'b0;
    bus.srcA        = $urandom;
    bus.srcB        = $urandom;
    bus.alu_control = 3'($urandom_range(0, 7));
    n = 0;
    ready_seen = 1'b0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (bus.out_valid) break;
      if (bus.in_ready) ready_seen = 1'b1;
      bus.in_valid = n[0];
    end
    bus.in_valid = 1'b0;
    check("latency", n, exp_latency(op));
    check("in_ready_busy", ready_seen, 0);
    e = exp_q.pop_front();
    check("alu_out", bus.alu_out, e[W-1:0]);
    check("alu_zero", bus.alu_zero, e[W-1:0] == 0);
    check("alu_compare", bus.alu_compare, e[W]);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.srcA     = $urandom;
      bus.srcB     = $urandom;
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("hold_out", bus.alu_out, e[W-1:0]);
      check("hold_valid", bus.out_valid, 1);
      check("hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("drain_valid", bus.out_valid, 0);
    check("drain_ready", bus.in_ready, 1);
  endtask

  initial begin
    int       hi_seen;
    logic [2:0] rop;
    logic [W-1:0] ra, rb;
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b0;
    bus.srcA        = '0;
    bus.srcB        = '0;
    bus.alu_control = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_alu_out", bus.alu_out, 0);
    check("rst_alu_zero", bus.alu_zero, 1);
    check("rst_compare", bus.alu_compare, 0);
    check("rst_state", dbg_state, 0);
    reset = 1'b0;

    // out_ready while nothing is pending must not disturb IDLE
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("idle_ready_state", dbg_state, 0);
    check("idle_ready_valid", bus.out_valid, 0);

    run_op(3'd0, 32'hFFFF_FFFF, 32'h1, 0);
    run_op(3'd3, 32'h8000_0000, 32'h24, 0);
    run_op(3'd1, 32'd5, 32'd5, 0);
    run_op(3'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 0);
    run_op(3'd4, 32'h0001_0003, 32'h0002_0005, 0);
    run_op(3'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(3'd5, 32'd100, 32'd7, 0);
    run_op(3'd6, 32'd100, 32'd7, 0);
    run_op(3'd5, 32'd5, 32'd0, 0);
    run_op(3'd6, 32'd5, 32'd0, 0);
    run_op(3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(3'd7, 32'h1234, 32'h1234, 0);
    run_op(3'd0, 32'h1234_5678, 32'h1111_1111, 5);
    run_op(3'd4, 32'd1234, 32'd5678, 5);

    for (int i = 0; i < 16; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 9)) : $urandom;
      run_op(rop, ra, rb, 0);
    end

    // Reset in the middle of a multiply: the result must never appear
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.srcA        = 32'h0001_0003;
    bus.srcB        = 32'h0002_0005;
    bus.alu_control = 3'd4;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("abort_busy", dbg_state, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_state", dbg_state, 0);
    check("abort_in_ready", bus.in_ready, 1);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_alu_out", bus.alu_out, 0);
    hi_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) hi_seen++;
    end
    check("abort_no_valid", hi_seen, 0);
    check("sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
